// File: rtl/net_share_arbiter.sv
// Round-robin sharing of one inference pipeline among NUM_REQ frame requesters.
// An in-order tag FIFO routes each network result back to the requester that sent the frame.
module net_share_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int IN_WIDTH     = 256,
    parameter int OUT_WIDTH    = 80,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*IN_WIDTH-1:0]   req_data_in,
    input  logic [NUM_REQ-1:0]            req_data_in_vaild,
    output logic [NUM_REQ-1:0]            req_data_in_ready,
    output logic [IN_WIDTH-1:0]           net_data_out,
    output logic                          net_data_out_vaild,
    input  logic                          net_data_out_ready,
    input  logic [OUT_WIDTH-1:0]          net_data_in,
    input  logic                          net_data_in_vaild,
    output logic                          net_data_in_ready,
    output logic [OUT_WIDTH-1:0]          rsp_data_out,
    output logic [NUM_REQ-1:0]            rsp_data_out_vaild,
    input  logic [NUM_REQ-1:0]            rsp_data_out_ready,
    output logic [$clog2(MAX_INFLIGHT):0] inflight_count,
    output logic                          err_orphan
);
    // state | meaning
    // IDLE  | no grant held; pick the next valid requester after last_win
    // GRANT | grant locked on one requester until its frame is accepted
    localparam int TW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] grant, grant_nxt;
    logic [TW-1:0] last_win, last_win_nxt;
    logic [TW-1:0] tag_mem [MAX_INFLIGHT];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] head;
    logic          fifo_empty, room, push, pop, orphan;
    logic          rr_found;
    logic [TW-1:0] rr_pick;
    int            rr_best, rr_dist;

    assign fifo_empty     = (count == '0);
    assign room           = (count < CW'(MAX_INFLIGHT));
    assign head           = tag_mem[rd_ptr];
    assign inflight_count = count;
    assign net_data_out   = req_data_in[int'(grant)*IN_WIDTH +: IN_WIDTH];
    assign rsp_data_out   = net_data_in;

    // Distance from last_win+1 going upward; the smallest distance among valid requesters wins.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_best  = NUM_REQ;
        rr_dist  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_dist = (i + 2*NUM_REQ - int'(last_win) - 1) % NUM_REQ;
            if (req_data_in_vaild[i] && (rr_dist < rr_best)) begin
                rr_best  = rr_dist;
                rr_found = 1'b1;
                rr_pick  = TW'(i);
            end
        end
    end

    always_comb begin
        state_nxt          = state;
        grant_nxt          = grant;
        last_win_nxt       = last_win;
        push               = 1'b0;
        net_data_out_vaild = 1'b0;
        req_data_in_ready  = '0;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    grant_nxt    = rr_pick;
                    last_win_nxt = rr_pick;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                net_data_out_vaild       = req_data_in_vaild[grant] && room;
                req_data_in_ready[grant] = net_data_out_ready && room;
                push = req_data_in_vaild[grant] && net_data_out_ready && room;
                if (push) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // An empty FIFO swallows results so a stray one cannot wedge the network.
    always_comb begin
        rsp_data_out_vaild = '0;
        net_data_in_ready  = 1'b1;
        pop                = 1'b0;
        orphan             = 1'b0;
        if (!fifo_empty) begin
            rsp_data_out_vaild[head] = net_data_in_vaild;
            net_data_in_ready        = rsp_data_out_ready[head];
            pop                      = net_data_in_vaild && rsp_data_out_ready[head];
        end else begin
            orphan = net_data_in_vaild;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_win   <= TW'(NUM_REQ - 1);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            last_win <= last_win_nxt;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (orphan) err_orphan <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= grant;
    end
endmodule

// File: doc/net_share_arbiter.md
# net_share_arbiter

Shares one `top_network` inference pipeline between up to four independent frame requesters. It is placed between the requesters and the network's `data_in_top`/`data_out_top` valid/ready ports. A round-robin arbiter grants one frame at a time into the network. An in-order tag FIFO records which requester each accepted frame came from, so every network result is returned only to that requester. The network preserves frame order, so in-order tagging is sufficient.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; legal range 2..4.
- `IN_WIDTH`, 256: frame width; matches the network input width.
- `OUT_WIDTH`, 80: result width; matches the network output width.
- `MAX_INFLIGHT`, 4: tag FIFO depth, i.e. the maximum number of frames inside the network; power of two, 2..16.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_data_in`  in  NUM_REQ*IN_WIDTH  frame from requester i, at bits [i*IN_WIDTH +: IN_WIDTH].
- `req_data_in_vaild`  in  NUM_REQ  per-requester frame valid.
- `req_data_in_ready`  out  NUM_REQ  per-requester frame accepted.
- `net_data_out`  out  IN_WIDTH  frame to the network `data_in_top`.
- `net_data_out_vaild`  out  1  frame valid to the network.
- `net_data_out_ready`  in  1  network input ready.
- `net_data_in`  in  OUT_WIDTH  result from the network `data_out_top`.
- `net_data_in_vaild`  in  1  result valid from the network.
- `net_data_in_ready`  out  1  ready to the network output.
- `rsp_data_out`  out  OUT_WIDTH  result, shared by all requesters.
- `rsp_data_out_vaild`  out  NUM_REQ  one-hot result valid to the owning requester.
- `rsp_data_out_ready`  in  NUM_REQ  per-requester result ready.
- `inflight_count`  out  $clog2(MAX_INFLIGHT)+1  number of frames accepted but not yet returned.
- `err_orphan`  out  1  sticky flag: a result arrived while no frame was in flight.

## Operation
- State machine has two states, IDLE and GRANT, plus a registered `grant` index and a `last_win` index.
- IDLE:
  - If any `req_data_in_vaild[i]` is 1, choose the first valid index searching `last_win+1, last_win+2, …` modulo NUM_REQ.
  - Register it into `grant` and `last_win`, then go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `net_data_out` = `req_data_in[grant]`.
  - `net_data_out_vaild` = `req_data_in_vaild[grant]` AND (`inflight_count` < MAX_INFLIGHT).
  - `req_data_in_ready[grant]` = `net_data_out_ready` AND (`inflight_count` < MAX_INFLIGHT). All other ready bits are 0.
  - An input handshake pushes `grant` into the tag FIFO and returns to IDLE.
  - The grant is locked until its handshake. Requesters must hold valid and data stable until ready; dropping valid while granted is a requester protocol violation and is not recovered.
- Response path is combinational and driven from the FIFO head `h`:
  - `rsp_data_out` = `net_data_in`.
  - `rsp_data_out_vaild[h]` = `net_data_in_vaild` AND FIFO non-empty; all other valid bits are 0.
  - `net_data_in_ready` = `rsp_data_out_ready[h]` AND non-empty.
  - An output handshake pops the FIFO.
- Orphan result: when the FIFO is empty, `net_data_in_ready` = 1 and `net_data_in` is discarded. If `net_data_in_vaild` = 1 in that case, `err_orphan` is set and stays set until `rst`.
- `inflight_count` is +1 on a push, −1 on a pop, and unchanged when both happen in the same cycle.
- The full check uses the registered count. There is no same-cycle bypass: at the full count a simultaneous pop does not enable a push in that cycle.
- Width rule: FIFO entries are $clog2(NUM_REQ) bits wide, with a minimum of 1.

## Timing
- Reset values:
  - state IDLE, `grant` = 0, `last_win` = NUM_REQ−1 (so requester 0 wins first).
  - FIFO empty, `inflight_count` = 0, `err_orphan` = 0.
  - All `*_vaild` and `*_ready` outputs are 0, except `net_data_in_ready`, which is 1 because the FIFO is empty.
  - `net_data_out` and `rsp_data_out` follow the selected inputs.
- Grant latency: requester valid in IDLE at cycle N gives `net_data_out_vaild` at cycle N+1 at the earliest.
- An input handshake at cycle M gives IDLE at M+1 and the next grant at M+2. Peak rate is one frame per 2 cycles.
- Response latency: 0 cycles from network to requester (combinational). The pop takes effect at the next edge.
- Reset mid-operation: all tags and the count are discarded within one cycle. The network shares `rst`, so no stale results are expected afterwards.

## Test plan
- After reset, requester 0 and requester 1 are both valid continuously and the network is always ready.
  -> Accepted order is 0,1,0,1.
  -> `net_data_out_vaild` is high on every second cycle.
  -> `inflight_count` increments 1,2,3,4 and then stalls at 4 with valid low.
- `MAX_INFLIGHT`=4 is full; the network returns one result while requester 1 is waiting.
  -> The pop and the blocked push occur in the same cycle.
  -> Count goes to 3, and the push happens on the next GRANT cycle.
- Results return for tags 0,1,0 while `rsp_data_out_ready`[1] is held low for 3 cycles.
  -> `rsp_data_out_vaild` is one-hot, `rsp_data_out_vaild`[1] is held high, and `net_data_in_ready` is 0 for those 3 cycles.
  -> The second tag-0 result is not delivered early.
- The network result has `net_data_in_vaild`=1 with the FIFO empty and `net_data_in`=80'h5A.
  -> `net_data_in_ready`=1, no `rsp_data_out_vaild` is asserted, and `err_orphan`=1 until `rst`.
- Only requester 1 is valid with `net_data_out_ready`=0 for 5 cycles, then it goes to 1.
  -> The grant stays on 1, `req_data_in_ready`[1]=0 for those 5 cycles, and one push of tag 1 occurs.
- `rst` is asserted with 3 frames in flight and a grant pending.
  -> The next cycle shows `inflight_count`=0, state IDLE, all valids 0, and requester 0 as the first winner.
